// File: rtl/uart_sched_pkg.sv
// Shared encodings for the UART2 TX scheduler: FSM states, header format, defaults.
// ST_CSUM exists only when UART_TX_SCHED_CHECKSUM_EN is defined.
package uart_sched_pkg;

  localparam int         ID_W         = 3;
  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
`ifdef UART_TX_SCHED_CHECKSUM_EN
    ST_WAIT = 3'd4,
    ST_CSUM = 3'd5
`else
    ST_WAIT = 3'd4
`endif
  } state_t;

  // Which kind of byte the current SEND/WAIT pair is carrying.
  typedef enum logic [1:0] {
    PH_HDR  = 2'd0,
    PH_BODY = 2'd1,
    PH_CSUM = 2'd2
  } phase_t;

  function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [ID_W-1:0] id);
    return base | {{(8-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester after last_grant wins; one-hot grant plus index.
// Purely combinational, no backpressure of its own.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant == '0 && req[i] && i == (int'(last_grant) + off) % N_REQ) begin
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin share of UART2 TX: header, payload (+ XOR checksum with UART_TX_SCHED_CHECKSUM_EN).
// Header strobe two cycles after the grant; stalls on requester VALID low or TX_BUSY, nothing dropped.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int         N_REQ     = 4,
  parameter logic [7:0] HDR_BASE  = HDR_BASE_DEF,
  parameter int         MAX_PKT   = 64,
  parameter int         GUARD_CYC = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     REQ_VALID,
  input  logic [8*N_REQ-1:0]   REQ_DATA,
  input  logic [N_REQ-1:0]     REQ_LAST,
  output logic [N_REQ-1:0]     REQ_READY,
  output logic [15:0]          TX_DATA,
  output logic                 TX_DATA_VAL,
  input  logic                 TX_BUSY,
  output logic [ID_W-1:0]      GRANT_ID,
  output logic                 ACTIVE
);

  localparam logic [7:0] MAX_CNT  = 8'(MAX_PKT);
  // The strobe cycle itself is the first ignored cycle, giving a 2+GUARD_CYC strobe spacing.
  localparam logic [7:0] GUARD_M1 = (GUARD_CYC > 0) ? 8'(GUARD_CYC - 1) : 8'd0;

  state_t           state;
  phase_t           phase;
  logic [N_REQ-1:0] gnt_mask;
  logic [7:0]       count;
  logic [7:0]       guard;
  logic             last_seen;
`ifdef UART_TX_SCHED_CHECKSUM_EN
  logic [7:0]       cks;
`endif

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic [7:0]       sel_dat;
  logic             sel_last;
  logic             sel_vld;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (REQ_VALID),
    .last_grant (GRANT_ID),
    .grant      (arb_gnt),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    sel_dat  = '0;
    sel_last = 1'b0;
    sel_vld  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_mask[i]) begin
        sel_dat  = REQ_DATA[8*i +: 8];
        sel_last = REQ_LAST[i];
        sel_vld  = REQ_VALID[i];
      end
    end
  end

  assign REQ_READY = (state == ST_LOAD) ? (REQ_VALID & gnt_mask) : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      phase       <= PH_HDR;
      GRANT_ID    <= ID_W'(N_REQ - 1);
      gnt_mask    <= '0;
      ACTIVE      <= 1'b0;
      TX_DATA     <= '0;
      TX_DATA_VAL <= 1'b0;
      count       <= '0;
      guard       <= '0;
      last_seen   <= 1'b0;
`ifdef UART_TX_SCHED_CHECKSUM_EN
      cks         <= '0;
`endif
    end else begin
      TX_DATA_VAL <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|REQ_VALID) begin
            GRANT_ID <= arb_idx;
            gnt_mask <= arb_gnt;
            ACTIVE   <= 1'b1;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          TX_DATA     <= {8'h00, hdr_byte(HDR_BASE, GRANT_ID)};
          TX_DATA_VAL <= 1'b1;
          count       <= '0;
          last_seen   <= 1'b0;
          phase       <= PH_HDR;
`ifdef UART_TX_SCHED_CHECKSUM_EN
          cks         <= hdr_byte(HDR_BASE, GRANT_ID);
`endif
          state       <= ST_SEND;
        end
        ST_LOAD: begin
          if (sel_vld) begin
            TX_DATA     <= {8'h00, sel_dat};
            TX_DATA_VAL <= 1'b1;
            count       <= count + 8'd1;
            last_seen   <= sel_last;
            phase       <= PH_BODY;
`ifdef UART_TX_SCHED_CHECKSUM_EN
            cks         <= cks ^ sel_dat;
`endif
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          guard <= GUARD_M1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (guard != 8'd0) begin
            guard <= guard - 8'd1;
          end else if (!TX_BUSY) begin
            if (phase == PH_HDR) begin
              state <= ST_LOAD;
            end else if (phase == PH_BODY && !last_seen && count != MAX_CNT) begin
              state <= ST_LOAD;
`ifdef UART_TX_SCHED_CHECKSUM_EN
            end else if (phase == PH_BODY) begin
              state <= ST_CSUM;
`endif
            end else begin
              ACTIVE <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end
`ifdef UART_TX_SCHED_CHECKSUM_EN
        ST_CSUM: begin
          TX_DATA     <= {8'h00, cks};
          TX_DATA_VAL <= 1'b1;
          phase       <= PH_CSUM;
          state       <= ST_SEND;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
